pc_gen: RTL and testbench
=========================

// Module: pc_gen
// PURPOSE
//   Parametrised program-counter generator for the IF stage of the pipelined MIPS core.
//   Holds the fetch PC and steps it by STEP each unstalled cycle.
//   Takes redirects from exception entry, ERET and branch/jump with fixed priority.
//   Buffers a redirect that arrives during a stall, so no redirect is lost.
// PARAMETERS
//   WIDTH      32            PC width in bits
//   RESET_VEC  32'hBFC00000  PC after reset (MIPS boot vector)
//   EXC_VEC    32'hBFC00380  exception entry target
//   STEP       4             sequential increment
// PORTS
//   clk        in   1      rising-edge clock
//   rst_n      in   1      asynchronous reset, active low
//   stall      in   1      1 = hold PC (IF stall)
//   exc_req    in   1      exception entry request (target EXC_VEC)
//   eret_req   in   1      ERET request
//   eret_addr  in   WIDTH  ERET target (EPC)
//   br_req     in   1      branch/jump taken request
//   br_addr    in   WIDTH  branch/jump target
//   pc         out  WIDTH  current fetch PC (registered)
//   pc_plus    out  WIDTH  pc + STEP (combinational, wraps mod 2^WIDTH)
//   redir      out  1      1 = pc was loaded from a redirect on the last edge
//   pend       out  1      1 = buffered redirect waiting for stall release
//   adel       out  1      fetch address error: pc[1:0] != 2'b00 (combinational)
// BEHAVIOUR
//   Reset (rst_n=0, async, no clock needed):
//     pc=RESET_VEC, redir=0, pend=0, pending class=none, pending addr=0.
//   Priority classes: EXC(3) > ERET(2) > BR(1) > none(0).
//   Each rising edge, first matching case applies:
//     a) exc_req=1 (stall ignored): pc<=EXC_VEC; pending cleared; redir<=1.
//     b) stall=1: pc held; redir<=0.
//        Live eret/br of higher class than pending overwrites pending (class, addr).
//        Same class: live overwrites pending. Lower class: ignored.
//     c) stall=0 with live eret/br or pend=1: pc <= target of highest class among
//        live and pending. Tie: live wins. pending cleared; redir<=1.
//     d) otherwise: pc<=pc+STEP; redir<=0.
//   pend = (pending class != none). pend rises the edge after a stalled redirect.
//   pend falls on the edge that applies the redirect or on exception.
//   Latency: redirect visible on pc one edge after request (or after stall release).
//   Arithmetic: pc+STEP truncated to WIDTH; wraps 0xFFFFFFFC -> 0x00000000 (STEP=4).
//   Redirect targets loaded verbatim: low bits are not masked.
//     A misaligned target raises adel while pc holds it; pc keeps stepping from it.
//   eret_req and br_req in the same unstalled cycle: ERET taken, branch dropped.
//   Reset asserted mid-stall or with pend=1: all state returns to reset values at once.
// TESTING
//   1. Reset release, stall=0, no req, 3 clocks -> pc: BFC00000, BFC00004, BFC00008, BFC0000C; redir=0.
//   2. br_req=1, br_addr=80001000 for 1 cycle -> next pc=80001000, redir=1 for one cycle, then 80001004.
//   3. stall=1; br_req with 80002000 during stall -> pend=1, pc held.
//      Release stall -> pc=80002000, pend=0.
//   4. stall=1; br 80003000, then eret 80004000, then br 80005000 -> pending keeps ERET 80004000.
//      Release -> pc=80004000.
//   5. stall=1 with pend=1, exc_req=1 -> pc=BFC00380 on that edge; pend=0; redir=1.
//   6. eret_addr=80000002 -> pc=80000002, adel=1.
//      Separately, pc=FFFFFFFC with no req -> next pc=00000000.
//      rst_n=0 mid-run -> pc=BFC00000 immediately.

Source files
------------

// File: rtl/pc_gen_if.sv
// pc_gen_if: request/redirect inputs and PC outputs of the fetch PC generator.
interface pc_gen_if #(parameter int WIDTH = 32);
    logic             stall;
    logic             exc_req;
    logic             eret_req;
    logic [WIDTH-1:0] eret_addr;
    logic             br_req;
    logic [WIDTH-1:0] br_addr;
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] pc_plus;
    logic             redir;
    logic             pend;
    logic             adel;
    modport master (
        output stall, exc_req, eret_req, eret_addr, br_req, br_addr,
        input  pc, pc_plus, redir, pend, adel
    );
    modport slave (
        input  stall, exc_req, eret_req, eret_addr, br_req, br_addr,
        output pc, pc_plus, redir, pend, adel
    );
endinterface

// File: rtl/pc_gen.sv
// pc_gen: IF-stage fetch PC with prioritised redirects and a one-entry stall redirect buffer.
module pc_gen #(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VEC = 32'hBFC00000,
    parameter logic [WIDTH-1:0] EXC_VEC   = 32'hBFC00380,
    parameter int               STEP      = 4
) (
    input logic        clk,
    input logic        rst_n,
    pc_gen_if.slave    bus
);
    logic [WIDTH-1:0] pc_q, pc_d, pa_q, pa_d, live_addr;
    logic [1:0]       pcls_q, pcls_d, live_cls;
    logic             redir_q, redir_d;
    assign live_cls  = bus.eret_req ? 2'd2 : bus.br_req ? 2'd1 : 2'd0;
    assign live_addr = bus.eret_req ? bus.eret_addr : bus.br_addr;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q    <= RESET_VEC;
            pa_q    <= '0;
            pcls_q  <= 2'd0;
            redir_q <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            pa_q    <= pa_d;
            pcls_q  <= pcls_d;
            redir_q <= redir_d;
        end
    end
    // Live request wins ties against the buffered one, both when buffering and when applying.
    always_comb begin
        pc_d    = pc_q;
        pa_d    = pa_q;
        pcls_d  = pcls_q;
        redir_d = 1'b0;
        if (bus.exc_req) begin
            pc_d    = EXC_VEC;
            pa_d    = '0;
            pcls_d  = 2'd0;
            redir_d = 1'b1;
        end else if (bus.stall) begin
            if (live_cls != 2'd0 && live_cls >= pcls_q) begin
                pa_d   = live_addr;
                pcls_d = live_cls;
            end
        end else if (live_cls != 2'd0 || pcls_q != 2'd0) begin
            pc_d    = (live_cls >= pcls_q) ? live_addr : pa_q;
            pa_d    = '0;
            pcls_d  = 2'd0;
            redir_d = 1'b1;
        end else begin
            pc_d = pc_q + WIDTH'(STEP);
        end
    end
    assign bus.pc      = pc_q;
    assign bus.pc_plus = pc_q + WIDTH'(STEP);
    assign bus.redir   = redir_q;
    assign bus.pend    = pcls_q != 2'd0;
    assign bus.adel    = pc_q[1:0] != 2'b00;
endmodule

// File: tb/tb_pc_gen.sv
// tb_pc_gen: directed checks of reset, stepping, redirect priority, stall buffering and wrap.
module tb_pc_gen;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   passed = 0;
    int   total = 0;
    pc_gen_if #(.WIDTH(32)) bus ();
    pc_gen dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    always #5 clk = ~clk;
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask
    initial begin
        bus.stall = 0; bus.exc_req = 0; bus.eret_req = 0; bus.br_req = 0;
        bus.eret_addr = '0; bus.br_addr = '0;
        #1 rst_n = 1'b0;
        #1;
        chk("rst_pc", bus.pc, 32'hBFC00000);
        chk("rst_redir", {31'd0, bus.redir}, 0);
        chk("rst_pend", {31'd0, bus.pend}, 0);
        @(negedge clk) rst_n = 1'b1;
        tick(); chk("seq1", bus.pc, 32'hBFC00004);
        tick(); chk("seq2", bus.pc, 32'hBFC00008);
        tick(); chk("seq3", bus.pc, 32'hBFC0000C);
        chk("seq_redir", {31'd0, bus.redir}, 0);
        bus.br_req = 1; bus.br_addr = 32'h80001000;
        tick(); bus.br_req = 0;
        chk("br_pc", bus.pc, 32'h80001000);
        chk("br_redir", {31'd0, bus.redir}, 1);
        tick();
        chk("br_next", bus.pc, 32'h80001004);
        chk("br_redir_off", {31'd0, bus.redir}, 0);
        bus.stall = 1; bus.br_req = 1; bus.br_addr = 32'h80002000;
        tick(); bus.br_req = 0;
        chk("stl_pend", {31'd0, bus.pend}, 1);
        chk("stl_hold", bus.pc, 32'h80001004);
        tick();
        chk("stl_hold2", bus.pc, 32'h80001004);
        bus.stall = 0;
        tick();
        chk("stl_rel_pc", bus.pc, 32'h80002000);
        chk("stl_rel_pend", {31'd0, bus.pend}, 0);
        chk("stl_rel_redir", {31'd0, bus.redir}, 1);
        bus.stall = 1; bus.br_req = 1; bus.br_addr = 32'h80003000;
        tick(); bus.br_req = 0; bus.eret_req = 1; bus.eret_addr = 32'h80004000;
        tick(); bus.eret_req = 0; bus.br_req = 1; bus.br_addr = 32'h80005000;
        tick(); bus.br_req = 0;
        chk("prio_pend", {31'd0, bus.pend}, 1);
        chk("prio_hold", bus.pc, 32'h80002000);
        bus.stall = 0;
        tick();
        chk("prio_pc", bus.pc, 32'h80004000);
        bus.stall = 1; bus.br_req = 1; bus.br_addr = 32'h80006000;
        tick(); bus.br_req = 0;
        chk("exc_pend_before", {31'd0, bus.pend}, 1);
        bus.exc_req = 1;
        tick(); bus.exc_req = 0;
        chk("exc_pc", bus.pc, 32'hBFC00380);
        chk("exc_pend", {31'd0, bus.pend}, 0);
        chk("exc_redir", {31'd0, bus.redir}, 1);
        bus.stall = 0;
        tick();
        chk("exc_after", bus.pc, 32'hBFC00384);
        chk("exc_after_redir", {31'd0, bus.redir}, 0);
        bus.stall = 1; bus.br_req = 1; bus.br_addr = 32'h80007000;
        tick(); bus.stall = 0; bus.br_addr = 32'h80008000;
        tick(); bus.br_req = 0;
        chk("tie_live", bus.pc, 32'h80008000);
        bus.stall = 1; bus.eret_req = 1; bus.eret_addr = 32'h80009000;
        tick(); bus.stall = 0; bus.eret_req = 0; bus.br_req = 1; bus.br_addr = 32'h8000A000;
        tick(); bus.br_req = 0;
        chk("pend_beats_live", bus.pc, 32'h80009000);
        bus.eret_req = 1; bus.eret_addr = 32'h8000B000; bus.br_req = 1; bus.br_addr = 32'h8000C000;
        tick(); bus.eret_req = 0; bus.br_req = 0;
        chk("eret_over_br", bus.pc, 32'h8000B000);
        tick();
        chk("eret_br_dropped", bus.pc, 32'h8000B004);
        bus.eret_req = 1; bus.eret_addr = 32'h80000002;
        tick(); bus.eret_req = 0;
        chk("mis_pc", bus.pc, 32'h80000002);
        chk("mis_adel", {31'd0, bus.adel}, 1);
        chk("mis_plus", bus.pc_plus, 32'h80000006);
        tick();
        chk("mis_step", bus.pc, 32'h80000006);
        tick();
        chk("aligned_adel", {31'd0, bus.adel}, 1);
        bus.br_req = 1; bus.br_addr = 32'hFFFFFFFC;
        tick(); bus.br_req = 0;
        chk("wrap_pre", bus.pc, 32'hFFFFFFFC);
        chk("wrap_plus", bus.pc_plus, 32'h00000000);
        chk("wrap_adel", {31'd0, bus.adel}, 0);
        tick();
        chk("wrap_pc", bus.pc, 32'h00000000);
        bus.stall = 1; bus.br_req = 1; bus.br_addr = 32'h12345678;
        tick(); bus.br_req = 0;
        chk("rst_mid_pend", {31'd0, bus.pend}, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_pc", bus.pc, 32'hBFC00000);
        chk("rst_mid_pend0", {31'd0, bus.pend}, 0);
        @(negedge clk) begin rst_n = 1'b1; bus.stall = 0; end
        tick();
        chk("rst_mid_after", bus.pc, 32'hBFC00004);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
